// File: rtl/keccak_state_loader_if.sv
// rtl/keccak_state_loader_if.sv - lane-word input stream and assembled-state output handshake
interface keccak_state_loader_if;
    logic [63:0]   i_v_word;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic [1599:0] o_v_data;
    logic          o_valid;
    logic          i_ready;
    logic [4:0]    o_lane_cnt;

    modport master (
        output i_v_word, i_valid, i_last, i_ready,
        input  o_ready, o_v_data, o_valid, o_lane_cnt
    );

    modport slave (
        input  i_v_word, i_valid, i_last, i_ready,
        output o_ready, o_v_data, o_valid, o_lane_cnt
    );
endinterface

// File: rtl/keccak_state_loader.sv
// rtl/keccak_state_loader.sv - assembles a 1600-bit Keccak state from 64-bit lane words
module keccak_state_loader (
    input  logic                  i_clk,
    input  logic                  i_rst,
    keccak_state_loader_if.slave  bus
);
    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = LANE_W * NUM_LANES;

    typedef enum logic {FILL, FULL} state_t;

    state_t               state;
    logic [STATE_W-1:0]   data_q;
    logic [4:0]           cnt_q;
    logic                 valid_q;
    logic                 ready_q;
    logic [10:0]          lane_base;

    assign lane_base = {cnt_q, 6'd0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= FILL;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (state == FILL) begin
            if (bus.i_valid && ready_q) begin
                data_q[lane_base +: LANE_W] <= bus.i_v_word;
                cnt_q                       <= cnt_q + 5'd1;
                if (cnt_q == 5'(NUM_LANES - 1) || bus.i_last) begin
                    state   <= FULL;
                    ready_q <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end else begin
            // Clearing on the way back to FILL is what zero-fills lanes after an early i_last.
            if (bus.i_ready) begin
                state   <= FILL;
                data_q  <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_v_data   = data_q;
    assign bus.o_lane_cnt = cnt_q;
endmodule

// File: doc/keccak_state_loader.md
Name: keccak_state_loader

Overview:
- Upstream neighbour of the Keccak 16-bit lane shuffle stage.
- Assembles a 1600-bit Keccak state from a stream of 64-bit lane words.
- Holds the assembled state and presents it with a valid/ready handshake to the shuffle/permutation path.
- Supports early termination: lanes not received are zero-filled.

Parameters:
- LANE_W, 64, width of one lane word; fixed at 64.
- NUM_LANES, 25, lanes per state; fixed at 25.
- STATE_W, 1600, LANE_W*NUM_LANES; derived, not overridable.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous reset, active-high.
- i_v_word  input  64  incoming lane word.
- i_valid  input  1  i_v_word/i_last are valid.
- i_last  input  1  final word of this state; qualified by i_valid.
- o_ready  output  1  loader accepts a word this cycle.
- o_v_data  output  1600  assembled state, lane k at bits [64k+63:64k].
- o_valid  output  1  o_v_data holds a complete state.
- i_ready  input  1  downstream accepts o_v_data.
- o_lane_cnt  output  5  lanes written so far in the current fill (0..25).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst; it takes priority over all other inputs.
- Reset values:
  - state FILL
  - o_lane_cnt = 0
  - o_v_data = all zeros
  - o_valid = 0
  - o_ready = 1 (from the first cycle after reset)
- States:
  - FILL: o_ready = 1, o_valid = 0.
  - FULL: o_ready = 0, o_valid = 1.
- Accept condition: word accepted iff i_valid && o_ready.
- On accept in FILL:
  - Lane at index o_lane_cnt is written with i_v_word.
  - o_lane_cnt increments by 1.
  - No byte or halfword reordering; the downstream shuffle does that.
- FILL -> FULL: on the cycle that accepts the word with o_lane_cnt == 24, or any accepted word with i_last = 1.
  - o_valid rises the cycle after that accept (latency 1).
  - o_lane_cnt shows the number of lanes received (1..25).
- Early i_last (lane index < 24): all higher lanes read as zero. They are guaranteed zero because the buffer is cleared on entry to FILL.
- i_last on lane 24 behaves identically to no i_last on lane 24.
- No i_last by lane 24: the state is complete after 25 words. The next accepted word starts a new state.
- FULL:
  - o_v_data and o_valid stay stable until i_ready = 1.
  - i_valid is ignored (not accepted) while o_ready = 0.
- FULL -> FILL: on i_valid-independent handshake o_valid && i_ready. On the next cycle:
  - o_valid = 0
  - o_v_data = 0
  - o_lane_cnt = 0
  - o_ready = 1
- No same-cycle accept while FULL: minimum one-cycle bubble between states. Throughput is 26 cycles per full state with continuous input and i_ready held high.
- i_valid with i_last = 0 and X data while o_ready = 0 must not alter any output.
- Reset mid-fill or mid-FULL:
  - Partial or held state is discarded.
  - Outputs return to reset values on the next cycle.
  - No o_valid pulse is produced.
- i_last while i_valid = 0 is ignored.
- o_v_data is driven directly from the storage register; no combinational path from i_v_word to o_v_data.
- o_ready depends only on state; no combinational path from i_ready.

Test Plan:
- Full fill:
  - Stimulus: reset, then 25 words i_v_word = 64'h0000_0000_0000_00kk (kk = lane index 0..24), i_valid held, i_ready = 1.
  - Response: o_valid = 1 exactly one cycle after the 25th accept; o_v_data[64k+7:64k] = k; o_lane_cnt = 25; o_valid drops the following cycle.
- Early termination:
  - Stimulus: 3 words A5A5_A5A5_A5A5_A5A5, 0123_4567_89AB_CDEF, FFFF_FFFF_FFFF_FFFF, with i_last on the third.
  - Response: o_valid next cycle; lanes 0..2 match; o_v_data[1599:192] = 0; o_lane_cnt = 3.
- Backpressure:
  - Stimulus: complete a state with i_ready = 0 for 10 cycles while i_valid stays high with new data.
  - Response: o_v_data unchanged; o_ready = 0; no words consumed. After i_ready = 1 for one cycle, o_ready = 1 and the first pending word lands in lane 0.
- Stale-data clearing:
  - Stimulus: full state of all-ones words, drained; then a 1-word state 0x1 with i_last.
  - Response: o_v_data = 1600'h1 (upper lanes zero, not ones).
- Reset mid-fill:
  - Stimulus: 10 words accepted, assert i_rst one cycle, then 25 fresh words.
  - Response: no o_valid before the fresh 25th word; o_lane_cnt restarts at 0; old lanes absent.
- Gapped input:
  - Stimulus: i_valid toggling every other cycle over 25 words.
  - Response: o_lane_cnt advances only on accept cycles; final state identical to the gapless case.
